// File: rtl/secuenciador_compuertas.sv
// secuenciador_compuertas
//
// Sequences the coffee-bean classifier and the three diverter gates behind it.
// A bean is a 0->1 edge on bean_detect. After the sensors settle, the
// classifier is strobed once, its one-hot grade is captured, and after the
// conveyor travel delay the matching gate is held open for GATE_CYC cycles.
// Beans arriving while a sequence is in flight are dropped and flagged.
//
// Build option:
//   SEC_CONTADORES_EN  when defined, per-class saturating tallies exist and are
//                      readable through cnt_sel/cnt_out. When not defined,
//                      cnt_out is tied to 0 and clr_cnt clears only the flags.
//                      FSM and gate timing are the same in both builds.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   bean_detect  presence sensor (already synchronous to clk)
//   class_baja/class_media/class_alta  classifier grade, expected one-hot
//   cnt_sel      tally select: 0 baja, 1 media, 2 alta, 3 errors
//   clr_cnt      clears tallies and both sticky flags
//   sample_en    one-cycle sample strobe to the classifier
//   gate_baja/gate_media/gate_alta     diverter drives, at most one high
//   busy         high whenever the sequencer is not idle
//   err_flag     sticky: captured grade was not one-hot
//   ovr_flag     sticky: a bean arrived while busy and was dropped
//   cnt_out      selected tally (combinational read of registers)

module secuenciador_compuertas #(
  parameter int SETTLE_CYC = 4,
  parameter int TRAVEL_CYC = 16,
  parameter int GATE_CYC   = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bean_detect,
  input  logic             class_baja,
  input  logic             class_media,
  input  logic             class_alta,
  input  logic [1:0]       cnt_sel,
  input  logic             clr_cnt,
  output logic             sample_en,
  output logic             gate_baja,
  output logic             gate_media,
  output logic             gate_alta,
  output logic             busy,
  output logic             err_flag,
  output logic             ovr_flag,
  output logic [CNT_W-1:0] cnt_out
);

  // One down-counter is shared by the three timed phases; size it for the
  // longest one.
  localparam int MAX_CYC = (SETTLE_CYC > TRAVEL_CYC)
                         ? ((SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC)
                         : ((TRAVEL_CYC > GATE_CYC) ? TRAVEL_CYC : GATE_CYC);
  localparam int DLY_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [DLY_W-1:0] LD_SETTLE = DLY_W'(SETTLE_CYC - 1);
  localparam logic [DLY_W-1:0] LD_TRAVEL = DLY_W'(TRAVEL_CYC - 1);
  localparam logic [DLY_W-1:0] LD_GATE   = DLY_W'(GATE_CYC - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_SAMPLE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_TRAVEL  = 3'd4;
  localparam logic [2:0] ST_GATE    = 3'd5;

  logic [2:0]       state, state_nx;
  logic [DLY_W-1:0] cnt, cnt_nx;
  logic [2:0]       grade, grade_nx;   // {alta, media, baja}, one-hot once valid
  logic [2:0]       gate_q;
  logic             prev;
  logic             rise;
  logic [2:0]       cls;
  logic             cls_ok;
  logic             cap_err;
  logic             ovr_set;
  logic             inc_grade;
  logic [3:0]       inc;               // tally increments: {err, alta, media, baja}

  // prev powers up high so a sensor already covered at reset release is not
  // mistaken for a new bean.
  assign rise   = bean_detect & ~prev;
  assign cls    = {class_alta, class_media, class_baja};
  assign cls_ok = (cls == 3'b001) || (cls == 3'b010) || (cls == 3'b100);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    grade_nx  = grade;
    cap_err   = 1'b0;
    inc_grade = 1'b0;
    // Only one bean in flight: anything arriving outside IDLE is dropped.
    ovr_set   = rise && (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nx = ST_SETTLE;
          cnt_nx   = LD_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) state_nx = ST_SAMPLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      ST_SAMPLE: begin
        state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cls_ok) begin
          grade_nx = cls;
          cnt_nx   = LD_TRAVEL;
          state_nx = ST_TRAVEL;
        end else begin
          // No grade or multi-hot: nothing to divert, abandon this bean.
          cap_err  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_TRAVEL: begin
        if (cnt == '0) begin
          state_nx  = ST_GATE;
          cnt_nx    = LD_GATE;
          inc_grade = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_GATE: begin
        if (cnt == '0) state_nx = ST_IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign inc = {cap_err, {3{inc_grade}} & grade};

  // Outputs are registered from next-state so they line up with the state
  // they describe, with no decode glitches on the gate drives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      grade     <= '0;
      prev      <= 1'b1;
      sample_en <= 1'b0;
      busy      <= 1'b0;
      gate_q    <= '0;
      err_flag  <= 1'b0;
      ovr_flag  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      grade     <= grade_nx;
      prev      <= bean_detect;
      sample_en <= (state_nx == ST_SAMPLE);
      busy      <= (state_nx != ST_IDLE);
      gate_q    <= (state_nx == ST_GATE) ? grade_nx : 3'b000;
      if (clr_cnt) begin
        err_flag <= 1'b0;
        ovr_flag <= 1'b0;
      end else begin
        if (cap_err) err_flag <= 1'b1;
        if (ovr_set) ovr_flag <= 1'b1;
      end
    end
  end

  assign {gate_alta, gate_media, gate_baja} = gate_q;

`ifdef SEC_CONTADORES_EN
  // Index matches cnt_sel: 0 baja, 1 media, 2 alta, 3 errors.
  logic [CNT_W-1:0] tally [4];

  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      for (int i = 0; i < 4; i++) tally[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        // Saturate rather than wrap so a full counter still reads "many".
        if (inc[i] && (tally[i] != '1)) tally[i] <= tally[i] + 1'b1;
      end
    end
  end

  assign cnt_out = tally[cnt_sel];
`else
  assign cnt_out = '0;

  logic unused_cnt;
  assign unused_cnt = ^{cnt_sel, inc};
`endif

endmodule

// File: tb/tb_secuenciador_compuertas.sv
// Bench for secuenciador_compuertas: directed test-plan scenarios followed by
// a randomized phase, every output compared each cycle against a time-window
// model of a bean's life (offsets from the accepting edge).
module tb_secuenciador_compuertas;

  localparam int CNT_W = 2;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef SEC_CONTADORES_EN
  localparam bit TALLIES = 1'b1;
`else
  localparam bit TALLIES = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, bean_detect, clr_cnt;
  logic [2:0]       cls_in;            // {alta, media, baja}
  logic [1:0]       cnt_sel;
  logic             sample_en, gate_baja, gate_media, gate_alta;
  logic             busy, err_flag, ovr_flag;
  logic [CNT_W-1:0] cnt_out;

  secuenciador_compuertas #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bean_detect(bean_detect),
    .class_baja(cls_in[0]), .class_media(cls_in[1]), .class_alta(cls_in[2]),
    .cnt_sel(cnt_sel), .clr_cnt(clr_cnt), .sample_en(sample_en),
    .gate_baja(gate_baja), .gate_media(gate_media), .gate_alta(gate_alta),
    .busy(busy), .err_flag(err_flag), .ovr_flag(ovr_flag), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a bean accepted at edge job_n owns the sequencer for offsets
  // 1..30 (valid grade) or 1..6 (invalid grade). Grade read at offset 6,
  // tally bump at offset 22, sample strobe visible at offset 5, gate at 23..30.
  int       e = 0;
  bit       m_prev = 1'b1;
  bit       job_on = 1'b0;
  int       job_n = 0;
  bit       job_ok = 1'b0;
  bit [2:0] job_grade = 3'b000;
  int       m_tally [4] = '{0, 0, 0, 0};
  bit       m_err = 1'b0, m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit       rise, busy_now, ovr_set, err_set;
    bit [3:0] inc;
    int       d, last;
    e++;
    if (reset) begin
      job_on = 1'b0; m_prev = 1'b1; m_err = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < 4; i++) m_tally[i] = 0;
      return;
    end
    rise = bean_detect && !m_prev;
    m_prev = bean_detect;
    ovr_set = 1'b0; err_set = 1'b0; inc = 4'b0; busy_now = 1'b0;
    if (job_on) begin
      d = e - job_n;
      if (d == 6) begin
        if ($countones(cls_in) == 1) begin
          job_ok = 1'b1; job_grade = cls_in;
        end else begin
          job_ok = 1'b0; err_set = 1'b1; inc[3] = 1'b1;
        end
      end
      if (job_ok && d == 22) inc[2:0] = job_grade;
      last = job_ok ? 30 : 6;
      busy_now = (d <= last);
      if (!busy_now) job_on = 1'b0;
    end
    if (rise && busy_now) ovr_set = 1'b1;
    else if (rise) begin
      job_on = 1'b1; job_n = e; job_ok = 1'b1; job_grade = 3'b000;
    end
    if (clr_cnt) begin
      m_err = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < 4; i++) m_tally[i] = 0;
    end else begin
      if (err_set) m_err = 1'b1;
      if (ovr_set) m_ovr = 1'b1;
      for (int i = 0; i < 4; i++)
        if (inc[i] && m_tally[i] < SAT) m_tally[i]++;
    end
  endtask

  task automatic check_outputs();
    int       dp, last;
    bit       x_busy, x_smp;
    bit [2:0] x_gate;
    int       x_cnt;
    dp     = e + 1 - job_n;
    last   = job_ok ? 30 : 6;
    x_busy = job_on && dp <= last;
    x_smp  = job_on && dp == 5;
    x_gate = (job_on && job_ok && dp >= 23 && dp <= 30) ? job_grade : 3'b000;
    x_cnt  = TALLIES ? m_tally[cnt_sel] : 0;
    chk("busy",      {7'b0, busy},      {7'b0, x_busy});
    chk("sample_en", {7'b0, sample_en}, {7'b0, x_smp});
    chk("gates",     {5'b0, gate_alta, gate_media, gate_baja}, {5'b0, x_gate});
    chk("err_flag",  {7'b0, err_flag},  {7'b0, m_err});
    chk("ovr_flag",  {7'b0, ovr_flag},  {7'b0, m_ovr});
    chk("cnt_out",   {6'b0, cnt_out},   8'(x_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One-cycle sensor pulse; the edge inside this step is the bean's edge n.
  task automatic bean(input logic [2:0] c);
    cls_in = c;
    bean_detect = 1'b1;
    step();
    bean_detect = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bean_detect = 1'b0; clr_cnt = 1'b0; cls_in = 3'b000; cnt_sel = 2'd0;
    run(2);
    reset = 1'b0;
    run(2);

    // Single media bean with default timing.
    cnt_sel = 2'd1;
    bean(3'b010);
    run(35);
    chk("media_tally", {6'b0, cnt_out}, TALLIES ? 8'd1 : 8'd0);

    // No grade at capture: error path, short busy window.
    cnt_sel = 2'd3;
    bean(3'b000);
    run(10);
    chk("err_tally", {6'b0, cnt_out}, TALLIES ? 8'd1 : 8'd0);

    // Second bean at n+10 is dropped.
    cnt_sel = 2'd0;
    bean(3'b001);
    run(9);
    bean_detect = 1'b1;
    step();
    bean_detect = 1'b0;
    run(25);
    chk("baja_after_ovr", {6'b0, cnt_out}, TALLIES ? 8'd1 : 8'd0);

    // Five alta beans back to back saturate a 2-bit tally.
    cnt_sel = 2'd2;
    for (int k = 0; k < 5; k++) begin
      bean(3'b100);
      run(30);
    end
    run(3);
    chk("alta_sat", {6'b0, cnt_out}, TALLIES ? 8'(SAT) : 8'd0);

    // Reset during GATE, sensor held high through and after reset.
    cnt_sel = 2'd0;
    bean(3'b001);
    run(24);
    reset = 1'b1; bean_detect = 1'b1;
    step();
    chk("rst_gate", {7'b0, gate_baja}, 8'd0);
    reset = 1'b0;
    run(8);
    chk("held_no_start", {7'b0, busy}, 8'd0);
    bean_detect = 1'b0;
    run(3);

    // Clear coincident with the tally increment; gate still pulses.
    bean(3'b001);
    run(21);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("gate_after_clr", {7'b0, gate_baja}, 8'd1);
    run(10);
    chk("tally_cleared", {6'b0, cnt_out}, 8'd0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) bean_detect = ~bean_detect;
      if ($urandom_range(0, 3) != 0) cls_in = 3'b001 << $urandom_range(0, 2);
      else                           cls_in = 3'($urandom_range(0, 7));
      cnt_sel = 2'($urandom_range(0, 3));
      clr_cnt = ($urandom_range(0, 79) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; clr_cnt = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
